aes_decrypt: RTL and testbench
==============================

AES_DECRYPT -- requirements
Module: aes_decrypt

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all flops rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port load, input, 1 bit: sampled at clk edge; high captures key/cyphertext and (re)starts decryption.
REQ-004 SHALL have port key, input, 128 bits: AES-128 cipher key (round-0 key), FIPS-197 byte order, byte 0 = bits [127:120].
REQ-005 SHALL have port cyphertext, input, 128 bits: block to decrypt, same byte order.
REQ-006 SHALL have port done, output, 1 bit: high when plaintext holds a valid result.
REQ-007 SHALL have port plaintext, output, 128 bits: registered decryption result.

Function
REQ-008 SHALL implement the FIPS-197 AES-128 inverse cipher (not the equivalent inverse cipher), one round per clock.
REQ-009 SHALL use FSM states IDLE, KEYEXP, ADDK, ROUNDS, FINAL, DONE.
REQ-010 Any edge with load=1, in any state: state_reg<=cyphertext, rk<=key, rnd<=1, done<=0, next state KEYEXP; this takes priority over all other transitions.
REQ-011 KEYEXP, 10 edges: rk<=forward key step(rk, RCON[rnd]), rnd++; after the 10th edge rk=k10; next state ADDK.
REQ-012 ADDK, 1 edge: state_reg<=state_reg^rk; rk<=inverse key step(rk, RCON[10]); rnd<=9; next state ROUNDS.
REQ-013 ROUNDS, 9 edges (rnd 9..1): state_reg<=InvMixColumns(InvSubBytes(InvShiftRows(state_reg))^rk); rk<=inverse key step(rk, RCON[rnd]); rnd--; after rnd=1, rk=k0; next state FINAL.
REQ-014 FINAL, 1 edge: plaintext<=InvSubBytes(InvShiftRows(state_reg))^rk; done<=1; next state DONE.
REQ-015 Inverse key step per word: w[i-4]=w[i]^w[i-1] for i mod 4 != 0; w[i-4]=w[i]^SubWord(RotWord(w[i-1]))^Rcon for i mod 4 = 0; SubWord uses the forward S-box.
REQ-016 Latency SHALL be exactly 21 edges from the last edge with load=1 to the edge that sets done=1.
REQ-017 load held high SHALL recapture on every edge; processing starts on the first edge with load=0.
REQ-018 DONE SHALL hold done=1 and plaintext stable until the next load or reset.
REQ-019 load asserted mid-operation SHALL abort the current block with no done pulse; plaintext keeps its prior value.
REQ-020 plaintext SHALL change only on the FINAL edge, or on reset.
REQ-021 IDLE with load=0 SHALL remain IDLE; key and cyphertext are ignored outside load edges.
REQ-022 All GF(2^8) arithmetic SHALL be modulo x^8+x^4+x^3+x+1; InvMixColumns coefficients SHALL be {0e,0b,0d,09}.

Reset
REQ-023 reset=1 SHALL immediately force FSM=IDLE, done=0, plaintext=0, and state_reg, rk, rnd=0.
REQ-024 Reset asserted mid-operation SHALL abort with no done; after release, nothing occurs until load.
REQ-025 On the first edge after reset release with load=1, the block SHALL capture normally.

Structure
REQ-026 Package aes_pkg SHALL hold the SBOX and INV_SBOX 256x8 constant tables, the RCON[1..10] table, the FSM state enum typedef, and the gf_mul2 helper function.
REQ-027 A combinational sub-module aes_inv_round SHALL implement InvShiftRows, InvSubBytes, AddRoundKey, and optional InvMixColumns, with a bypass input used in FINAL.
REQ-028 Key stepping (forward and inverse) SHALL reside in aes_decrypt; no other sub-modules.
REQ-029 Total RTL SHALL be 120-400 lines, excluding the S-box tables.

Verification
REQ-030 Test: key=2b7e151628aed2a6abf7158809cf4f3c, cyphertext=3925841d02dc09fbdc118597196a0b32, 1-cycle load -> done rises exactly 21 edges later with plaintext=3243f6a8885a308d313198a2e0370734.
REQ-031 Test: key=000102030405060708090a0b0c0d0e0f, cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext=00112233445566778899aabbccddeeff.
REQ-032 Test: load held high 5 cycles, then low -> done rises 21 edges after the last high edge, with correct plaintext.
REQ-033 Test: REQ-030 vector, then reload with the REQ-031 vector at edge 10 -> no done for the first block; done rises 21 edges after the reload with the REQ-031 plaintext.
REQ-034 Test: assert reset at edge 15 of an operation -> done=0 and plaintext=0 immediately; done stays 0 until a new load, and the next load completes correctly.
REQ-035 Test: after done, hold load=0 for 50 cycles -> done stays 1 and plaintext is unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decryptor.
// Holds the forward and inverse S-box tables, the key-schedule round constants,
// the FSM state type and the GF(2^8) doubling helper.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYEXP,
        ADDK,
        ROUNDS,
        FINAL,
        DONE
    } aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Block-level bus of the AES-128 decryptor.
//   load       : capture key/cyphertext and (re)start decryption
//   key        : 128-bit cipher key, byte 0 in [127:120]
//   cyphertext : 128-bit block to decrypt
//   done       : plaintext holds a valid result
//   plaintext  : registered decryption result
interface aes_decrypt_if;
    logic         load;
    logic [127:0] key;
    logic [127:0] cyphertext;
    logic         done;
    logic [127:0] plaintext;

    modport master (output load, output key, output cyphertext, input done, input plaintext);
    modport slave  (input load, input key, input cyphertext, output done, output plaintext);
endinterface

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless bypass is set (last round).
//   state_in  : current state, byte 0 in [127:120], column-major
//   round_key : round key to add
//   bypass    : skip InvMixColumns
//   state_out : next state
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         bypass,
    output logic [127:0] state_out
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            m2[i] = gf_mul2(a[i]);
            m4[i] = gf_mul2(m2[i]);
            m8[i] = gf_mul2(m4[i]);
            m9[i] = m8[i] ^ a[i];
            mb[i] = m8[i] ^ m2[i] ^ a[i];
            md[i] = m8[i] ^ m4[i] ^ a[i];
            me[i] = m8[i] ^ m4[i] ^ m2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [127:0] added;
    logic [127:0] mixed;

    // Row r shifts right by r: output column c takes input column (c - r) mod 4.
    always_comb begin
        added = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                added[127 - 8 * (4 * c + r) -: 8] =
                    INV_SBOX[state_in[127 - 8 * (4 * ((c + 4 - r) % 4) + r) -: 8]]
                    ^ round_key[127 - 8 * (4 * c + r) -: 8];
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = inv_mix_col(added[127 - 32 * c -: 32]);
        end
    end

    assign state_out = bypass ? added : mixed;

endmodule

// File: rtl/aes_decrypt.sv
// AES-128 inverse cipher, one round per clock.
// The round-0 key is expanded forward to k10 (10 edges), then each inverse round
// steps the key back so no key schedule storage is needed.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : load/key/cyphertext in, done/plaintext out
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    aes_decrypt_if.slave bus
);

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one forward step: recover words from the right, then the first word.
    function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    aes_state_e   fsm, fsm_next;
    logic [127:0] state_reg, state_next;
    logic [127:0] rk, rk_next;
    logic [3:0]   rnd, rnd_next;
    logic         done_reg, done_next;
    logic [127:0] pt_reg, pt_next;
    logic [127:0] round_out;

    aes_inv_round u_round (
        .state_in  (state_reg),
        .round_key (rk),
        .bypass    (fsm == FINAL),
        .state_out (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            state_reg <= '0;
            rk        <= '0;
            rnd       <= '0;
            done_reg  <= 1'b0;
            pt_reg    <= '0;
        end else begin
            fsm       <= fsm_next;
            state_reg <= state_next;
            rk        <= rk_next;
            rnd       <= rnd_next;
            done_reg  <= done_next;
            pt_reg    <= pt_next;
        end
    end

    always_comb begin
        fsm_next   = fsm;
        state_next = state_reg;
        rk_next    = rk;
        rnd_next   = rnd;
        done_next  = done_reg;
        pt_next    = pt_reg;
        if (bus.load) begin
            // Load wins in every state; plaintext is left untouched on abort.
            state_next = bus.cyphertext;
            rk_next    = bus.key;
            rnd_next   = 4'd1;
            done_next  = 1'b0;
            fsm_next   = KEYEXP;
        end else begin
            unique case (fsm)
                IDLE: ;
                KEYEXP: begin
                    rk_next  = fwd_step(rk, RCON[rnd]);
                    rnd_next = rnd + 4'd1;
                    if (rnd == 4'd10) fsm_next = ADDK;
                end
                ADDK: begin
                    state_next = state_reg ^ rk;
                    rk_next    = inv_step(rk, RCON[10]);
                    rnd_next   = 4'd9;
                    fsm_next   = ROUNDS;
                end
                ROUNDS: begin
                    state_next = round_out;
                    rk_next    = inv_step(rk, RCON[rnd]);
                    rnd_next   = rnd - 4'd1;
                    if (rnd == 4'd1) fsm_next = FINAL;
                end
                FINAL: begin
                    pt_next   = round_out;
                    done_next = 1'b1;
                    fsm_next  = DONE;
                end
                DONE: ;
                default: fsm_next = IDLE;
            endcase
        end
    end

    assign bus.done      = done_reg;
    assign bus.plaintext = pt_reg;

endmodule

// File: tb/tb_aes_decrypt.sv
// Self-checking bench for aes_decrypt: a from-scratch AES-128 reference (S-boxes
// derived from GF(2^8) inverses, full key expansion, textbook inverse cipher)
// drives a cycle-level expectation of done/plaintext compared every cycle.
module tb_aes_decrypt;

    logic clk = 1'b0;
    logic reset;
    aes_decrypt_if bus ();

    aes_decrypt dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    logic [7:0] tsb [256];
    logic [7:0] tisb [256];

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sboxes();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bx = 8'(x);
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gm(bx, 8'(y)) == 8'h01) inv = 8'(y);
            end
            tsb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) tisb[tsb[x]] = 8'(x);
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] c);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc;
        logic [31:0] tmp;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tsb[tmp[23:16]], tsb[tmp[15:8]], tsb[tmp[7:0]], tsb[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) begin
            tmp = w[40 + i / 4];
            s[i] = c[127 - 8 * i -: 8] ^ tmp[31 - 8 * (i % 4) -: 8];
        end
        for (int r = 9; r >= 0; r--) begin
            for (int cc = 0; cc < 4; cc++)
                for (int row = 0; row < 4; row++)
                    t[4 * cc + row] = tisb[s[4 * ((cc + 4 - row) % 4) + row]];
            for (int i = 0; i < 16; i++) begin
                tmp = w[4 * r + i / 4];
                t[i] = t[i] ^ tmp[31 - 8 * (i % 4) -: 8];
            end
            for (int cc = 0; cc < 4; cc++) begin
                if (r > 0) begin
                    s[4*cc]   = gm(t[4*cc], 8'h0e) ^ gm(t[4*cc+1], 8'h0b)
                              ^ gm(t[4*cc+2], 8'h0d) ^ gm(t[4*cc+3], 8'h09);
                    s[4*cc+1] = gm(t[4*cc], 8'h09) ^ gm(t[4*cc+1], 8'h0e)
                              ^ gm(t[4*cc+2], 8'h0b) ^ gm(t[4*cc+3], 8'h0d);
                    s[4*cc+2] = gm(t[4*cc], 8'h0d) ^ gm(t[4*cc+1], 8'h09)
                              ^ gm(t[4*cc+2], 8'h0e) ^ gm(t[4*cc+3], 8'h0b);
                    s[4*cc+3] = gm(t[4*cc], 8'h0b) ^ gm(t[4*cc+1], 8'h0d)
                              ^ gm(t[4*cc+2], 8'h09) ^ gm(t[4*cc+3], 8'h0e);
                end else begin
                    for (int row = 0; row < 4; row++) s[4*cc+row] = t[4*cc+row];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // Expected outputs: done rises on the 21st load-free edge after the last load edge.
    logic [127:0] m_key, m_ct, m_pt;
    logic         m_done, m_busy;
    int           m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_done <= 1'b0;
            m_pt   <= '0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (bus.load) begin
            m_key  <= bus.key;
            m_ct   <= bus.cyphertext;
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 20) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_pt   <= ref_decrypt(m_key, m_ct);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_done", {127'h0, bus.done}, {127'h0, m_done});
            check("cyc_plaintext", bus.plaintext, m_pt);
        end
    end

    // Called at posedge+1; leaves load low at posedge+1 after the last load edge.
    task automatic start(input logic [127:0] k, input logic [127:0] c, input int n);
        bus.load       = 1'b1;
        bus.key        = k;
        bus.cyphertext = c;
        repeat (n) @(posedge clk);
        #1;
        bus.load       = 1'b0;
        bus.key        = {$urandom, $urandom, $urandom, $urandom};
        bus.cyphertext = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(input string name, input logic [127:0] exp_pt);
        int n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 128'(n), 128'd21);
        check({name, "_plaintext"}, bus.plaintext, exp_pt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, c, hold_pt;
        int mode;
        reset          = 1'b1;
        bus.load       = 1'b0;
        bus.key        = '0;
        bus.cyphertext = '0;
        build_sboxes();
        check("model_sbox_00", {120'h0, tsb[0]}, 128'h63);
        check("model_sbox_53", {120'h0, tsb[8'h53]}, 128'hed);
        check("model_fips_c1", ref_decrypt(K1, C1), P1);
        check("model_fips_c3", ref_decrypt(K2, C2), P2);

        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_done", {127'h0, bus.done}, 128'h0);
        check("reset_plaintext", bus.plaintext, 128'h0);
        chk_en = 1'b1;

        // Idle with load low: nothing happens.
        repeat (5) @(posedge clk);
        #1;
        check("idle_done", {127'h0, bus.done}, 128'h0);

        start(K1, C1, 1);
        wait_done("vec1", P1);
        start(K2, C2, 1);
        wait_done("vec2", P2);

        start(K1, C1, 5);
        wait_done("held_load", P1);

        // Abort by reload at edge 10.
        start(K1, C1, 1);
        repeat (9) @(posedge clk);
        #1;
        check("abort_no_done", {127'h0, bus.done}, 128'h0);
        check("abort_pt_kept", bus.plaintext, P1);
        start(K2, C2, 1);
        wait_done("reload", P2);

        // Reset at edge 15 of an operation.
        start(K1, C1, 1);
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_done", {127'h0, bus.done}, 128'h0);
        check("rst_mid_plaintext", bus.plaintext, 128'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("rst_no_done", {127'h0, bus.done}, 128'h0);
        start(K2, C2, 1);
        wait_done("after_rst", P2);

        // Hold in DONE.
        hold_pt = bus.plaintext;
        repeat (50) @(posedge clk);
        #1;
        check("hold_done", {127'h0, bus.done}, 128'h1);
        check("hold_plaintext", bus.plaintext, P2);
        check("hold_stable", bus.plaintext, hold_pt);

        for (int it = 0; it < 24; it++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            c = {$urandom, $urandom, $urandom, $urandom};
            mode = $urandom_range(0, 2);
            start(k, c, $urandom_range(1, 3));
            if (mode == 0) begin
                wait_done("rand", ref_decrypt(k, c));
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end else if (mode == 1) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
            end else begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #2;
                reset = 1'b1;
                @(posedge clk);
                #2;
                reset = 1'b0;
                @(posedge clk);
                #1;
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
